// File: rtl/demux16_capture.sv
// demux16_capture: steers a serial bit stream into a 16-bit word.
// Slots are filled either by an explicit index or by an internal pointer.
// Once every slot has been written the word is presented with out_valid
// and held until the consumer accepts it. Misuse is flagged by sticky
// drop/duplicate error bits.

// One storage slot: a data bit plus its "written this frame" flag.
module demux16_slot (
  input  logic clk,
  input  logic rst_n,
  input  logic zero_i,   // frame abort / frame consumed
  input  logic wr_i,     // write strobe for this slot
  input  logic din_i,
  output logic data_o,
  output logic fill_o
);

  logic data_q;
  logic fill_q;

  // Zeroing wins over a write; writes overwrite data and mark the slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= 1'b0;
      fill_q <= 1'b0;
    end else if (zero_i) begin
      data_q <= 1'b0;
      fill_q <= 1'b0;
    end else if (wr_i) begin
      data_q <= din_i;
      fill_q <= 1'b1;
    end
  end

  assign data_o = data_q;
  assign fill_o = fill_q;

endmodule

module demux16_capture #(
  parameter bit DUP_ERR_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_bit,
  input  logic [3:0]  sel,
  input  logic        wr_en,
  input  logic        auto_mode,
  input  logic        clear,
  input  logic        out_ready,
  output logic [15:0] out_data,
  output logic        out_valid,
  output logic [15:0] fill_mask,
  output logic        drop_err,
  output logic        dup_err
);

  localparam int NUM_SLOTS = 16;

  typedef enum logic {
    COLLECT = 1'b0,
    FULL    = 1'b1
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  ptr_q, ptr_d;
  logic        drop_q, drop_d;
  logic        dup_q, dup_d;

  logic [3:0]           slot;
  logic [NUM_SLOTS-1:0] slot_oh;
  logic                 accept;
  logic                 zero_all;
  logic [NUM_SLOTS-1:0] data_w;
  logic [NUM_SLOTS-1:0] fill_w;

  assign slot    = auto_mode ? ptr_q : sel;
  assign slot_oh = NUM_SLOTS'(1) << slot;

  // Next-state: collect writes until every slot is filled, then hold for
  // the handshake. clear overrides both a write and a handshake.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    drop_d   = drop_q;
    dup_d    = dup_q;
    accept   = 1'b0;
    zero_all = 1'b0;
    case (state_q)
      COLLECT: begin
        if (wr_en) begin
          accept = 1'b1;
          if (auto_mode) ptr_d = ptr_q + 4'd1;
          if (DUP_ERR_EN && ((fill_w & slot_oh) != '0)) dup_d = 1'b1;
          if ((fill_w | slot_oh) == '1) state_d = FULL;
        end
      end
      FULL: begin
        // The word is frozen: every offered bit is lost, even on the
        // handshake cycle.
        if (wr_en) drop_d = 1'b1;
        if (out_ready) begin
          state_d  = COLLECT;
          ptr_d    = '0;
          zero_all = 1'b1;
        end
      end
      default: state_d = COLLECT;
    endcase
    if (clear) begin
      state_d  = COLLECT;
      ptr_d    = '0;
      drop_d   = 1'b0;
      dup_d    = 1'b0;
      accept   = 1'b0;
      zero_all = 1'b1;
    end
  end

  // Control state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= COLLECT;
      ptr_q   <= '0;
      drop_q  <= 1'b0;
      dup_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      drop_q  <= drop_d;
      dup_q   <= dup_d;
    end
  end

  for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_slot
    demux16_slot u_slot (
      .clk    (clk),
      .rst_n  (rst_n),
      .zero_i (zero_all),
      .wr_i   (accept & slot_oh[i]),
      .din_i  (in_bit),
      .data_o (data_w[i]),
      .fill_o (fill_w[i])
    );
  end

  assign out_data  = data_w;
  assign fill_mask = fill_w;
  assign out_valid = (state_q == FULL);
  assign drop_err  = drop_q;
  assign dup_err   = dup_q;

endmodule

// File: doc/demux16_capture.md
DEMUX16_CAPTURE -- requirements
Module: demux16_capture

Interface
REQ-001 Parameter DUP_ERR_EN, default 1, meaning: when 1, a write to an already-filled slot sets dup_err.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 in_bit  input  1  serial data bit to be steered into one of 16 slots.
REQ-005 sel  input  4  slot index for in_bit in manual mode (0 = out_data[0]).
REQ-006 wr_en  input  1  write strobe; one bit offered per cycle when high.
REQ-007 auto_mode  input  1  1 = slot taken from the internal pointer, sel ignored; 0 = slot = sel.
REQ-008 clear  input  1  synchronous frame abort.
REQ-009 out_ready  input  1  consumer accepts the assembled word.
REQ-010 out_data  output  16  assembled word, registered.
REQ-011 out_valid  output  1  out_data holds a complete frame.
REQ-012 fill_mask  output  16  bit i = 1 when slot i has been written in the current frame.
REQ-013 drop_err  output  1  sticky: a write was discarded.
REQ-014 dup_err  output  1  sticky: a slot was written twice in one frame.

Function
REQ-015 The block SHALL implement two states, COLLECT and FULL; out_valid SHALL be 1 exactly in FULL.
REQ-016 In COLLECT, wr_en=1 SHALL write in_bit into out_data[slot] and set fill_mask[slot] on that edge; the other bits stay unchanged.
REQ-017 Slot SHALL be sel when auto_mode=0 and the internal 4-bit pointer ptr when auto_mode=1.
REQ-018 ptr SHALL increment by 1 only on an accepted auto-mode write, wrapping 15 -> 0. A manual write SHALL NOT change ptr.
REQ-019 A write to a slot whose fill_mask bit is already 1 SHALL overwrite the data bit. It SHALL leave fill_mask unchanged. It SHALL set dup_err when DUP_ERR_EN=1.
REQ-020 When a write makes fill_mask all ones, the state SHALL become FULL on that same edge, so out_valid is high the next cycle (latency 1 cycle from the 16th write).
REQ-021 In FULL, out_data and fill_mask SHALL hold stable until the handshake.
REQ-022 In FULL, any wr_en=1 SHALL be discarded and SHALL set drop_err. This includes the handshake cycle.
REQ-023 The handshake SHALL occur when out_valid=1 and out_ready=1 on the same edge.
REQ-024 On the handshake the state SHALL return to COLLECT, fill_mask SHALL clear to 0, out_data SHALL clear to 0, and ptr SHALL reset to 0.
REQ-025 out_ready while in COLLECT SHALL have no effect.
REQ-026 clear=1 SHALL, on the next edge, force COLLECT and zero out_data, fill_mask and ptr. It SHALL also zero drop_err and dup_err.
REQ-027 clear SHALL take priority over a write and over a handshake in the same cycle.
REQ-028 Switching auto_mode mid-frame SHALL be legal. Existing fill_mask and ptr SHALL be retained.
REQ-029 drop_err and dup_err SHALL remain set until clear or reset.

Reset
REQ-030 While rst_n=0, asynchronously: state=COLLECT, out_data=16'h0000, out_valid=0, fill_mask=16'h0000, ptr=0, drop_err=0, dup_err=0.
REQ-031 Reset asserted mid-frame or in FULL SHALL discard the partial or complete frame with no handshake.
REQ-032 Reset deassertion SHALL be the only reset requirement; the first write is accepted on the first rising edge with rst_n=1.

Verification
REQ-033 Auto mode, 16 consecutive writes of in_bit = bits of 16'hA5C3, LSB first -> out_valid=1 one cycle after the 16th write; out_data=16'hA5C3; fill_mask=16'hFFFF.
REQ-034 Manual mode, sel 15 down to 0 with in_bit=sel[0] -> out_data=16'hAAAA; out_valid only after the sel=0 write.
REQ-035 Frame FULL, out_ready=0 for 3 cycles with wr_en=1 -> out_data unchanged; drop_err=1. Then out_ready=1 -> out_valid=0 next cycle and fill_mask=0.
REQ-036 Write slot 5 twice (1 then 0) -> out_data[5]=0; fill_mask=16'h0020; dup_err=1.
REQ-037 8 auto writes, then clear=1 together with wr_en=1 -> fill_mask=0, ptr=0, the write is ignored, and both error flags are 0.
REQ-038 rst_n pulsed low mid-cycle during FULL -> outputs immediately at their reset values, without waiting for a clock edge.
